// File: rtl/timer_mc.sv
// Multi-channel timer bank: CHANNELS independent up/down/triangle counters
// advanced by one shared programmable prescaler tick.
module timer_mc #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [PRESC_W-1:0]        presc,
    input  logic [CHANNELS*WIDTH-1:0] top,
    input  logic [CHANNELS*2-1:0]     mode,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       irq_clr,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       wrap,
    output logic [CHANNELS-1:0]       irq,
    output logic [CHANNELS-1:0]       running
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0]   CntOne = WIDTH'(1);
    localparam logic [PRESC_W-1:0] PcOne  = PRESC_W'(1);

    logic [PRESC_W-1:0] pc_q;
    logic               tick;

    // Exact-match compare: a pc above a newly lowered presc rolls through 2^PRESC_W.
    assign tick = (pc_q == presc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= '0;
        end else if (tick) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_q + PcOne;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_e           state_q;
        logic [WIDTH-1:0] cnt_q, cnt_d, top_ch;
        logic [1:0]       md;
        logic             dir_q, dir_d;  // 0 = up, 1 = down
        logic             wrap_q, irq_q, ev, advance;

        assign md      = mode[2*i +: 2];
        assign top_ch  = top[i*WIDTH +: WIDTH];
        assign advance = (state_q == StRun) && en[i] && tick;

        always_comb begin
            cnt_d = cnt_q;
            dir_d = dir_q;
            ev    = 1'b0;
            case (md)
                2'b01: begin
                    dir_d = 1'b1;
                    if (cnt_q == '0) begin
                        ev    = 1'b1;
                        cnt_d = top_ch;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                2'b10: begin
                    if (top_ch == '0) begin
                        // Degenerate triangle: pinned at zero, wrapping every tick.
                        ev    = 1'b1;
                        cnt_d = '0;
                    end else if (!dir_q) begin
                        if (cnt_q >= top_ch) begin
                            ev    = 1'b1;
                            dir_d = 1'b1;
                            cnt_d = top_ch - CntOne;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            ev    = 1'b1;
                            dir_d = 1'b0;
                            cnt_d = CntOne;
                        end else begin
                            cnt_d = cnt_q - CntOne;
                        end
                    end
                end
                default: begin
                    dir_d = 1'b0;
                    if (cnt_q >= top_ch) begin
                        ev    = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                dir_q   <= 1'b0;
                wrap_q  <= 1'b0;
                irq_q   <= 1'b0;
            end else begin
                wrap_q <= 1'b0;
                if (start[i]) begin
                    state_q <= StRun;
                    cnt_q   <= (md == 2'b01) ? top_ch : '0;
                    dir_q   <= (md == 2'b01);
                end else if (advance) begin
                    if (ev) begin
                        wrap_q <= 1'b1;
                    end
                    if (ev && oneshot[i]) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_d;
                        dir_q <= dir_d;
                    end
                end
                // Set beats clear when both land on the same edge.
                if (advance && ev && !start[i]) begin
                    irq_q <= 1'b1;
                end else if (irq_clr[i]) begin
                    irq_q <= 1'b0;
                end
            end
        end

        assign cnt[i*WIDTH +: WIDTH] = cnt_q;
        assign wrap[i]               = wrap_q;
        assign irq[i]                = irq_q;
        assign running[i]            = (state_q == StRun);
    end

endmodule

// File: tb/tb_timer_mc.sv
// Directed bench for timer_mc: vector table for single-tick behaviour plus
// hand sequences for prescaled one-shot, restart and mid-count reset.
module tb_timer_mc;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned PW = 8;

    logic            clk, rstn;
    logic [PW-1:0]   presc;
    logic [CH*W-1:0] top;
    logic [CH*2-1:0] mode;
    logic [CH-1:0]   oneshot, en, start, irq_clr;
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   wrap, irq, running;

    timer_mc #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .presc   (presc),
        .top     (top),
        .mode    (mode),
        .oneshot (oneshot),
        .en      (en),
        .start   (start),
        .irq_clr (irq_clr),
        .cnt     (cnt),
        .wrap    (wrap),
        .irq     (irq),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         ch;
        logic       st, en, clr, os;
        logic [1:0] md;
        logic [7:0] tp;
        logic [7:0] cnt;
        logic       wr, irq, run;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int ch, logic st, logic e, logic clr, logic [1:0] md,
                                logic [7:0] tp, logic [7:0] c, logic wr, logic iq, logic run);
        vec_t v;
        v.ch = ch; v.st = st; v.en = e; v.clr = clr; v.os = 1'b0; v.md = md; v.tp = tp;
        v.cnt = c; v.wr = wr; v.irq = iq; v.run = run;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rstn = 1'b0; presc = '0; top = '0; mode = '0; oneshot = '0;
        en = '0; start = '0; irq_clr = '0;
        #12;
        chk("reset cnt", cnt, 32'h0);
        chk("reset wrap", {28'h0, wrap}, 32'h0);
        chk("reset irq", {28'h0, irq}, 32'h0);
        chk("reset running", {28'h0, running}, 32'h0);

        // ch1 down, top=5, one-shot, tick every 3 clk; ticks land on edges 3,6,...
        presc = 8'd2;
        top[15:8] = 8'd5; mode[3:2] = 2'b01; oneshot[1] = 1'b1; en[1] = 1'b1; start[1] = 1'b1;
        rstn = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) start[1] = 1'b0;
            n = k / 3;
            chk($sformatf("os k%0d cnt", k), {24'h0, cnt[15:8]}, (n <= 5) ? 32'(5 - n) : 32'h0);
            chk($sformatf("os k%0d wrap", k), {31'h0, wrap[1]}, {31'h0, k == 18});
            chk($sformatf("os k%0d run", k), {31'h0, running[1]}, {31'h0, k < 18});
            chk($sformatf("os k%0d irq", k), {31'h0, irq[1]}, {31'h0, k >= 18});
        end
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk("rerun cnt", {24'h0, cnt[15:8]}, 32'd5);
        chk("rerun run", {31'h0, running[1]}, 32'd1);

        // Everything counting, then asynchronous reset mid-count.
        mode = '0; oneshot = '0; top = {4{8'd20}}; en = '1; start = '1;
        step();
        start = '0;
        repeat (7) step();
        rstn = 1'b0;
        #2;
        chk("midrst cnt", cnt, 32'h0);
        chk("midrst wrap", {28'h0, wrap}, 32'h0);
        chk("midrst irq", {28'h0, irq}, 32'h0);
        chk("midrst running", {28'h0, running}, 32'h0);
        presc = '0;
        #2;
        rstn = 1'b1;
        repeat (3) step();
        chk("post-rst cnt", cnt, 32'h0);
        chk("post-rst running", {28'h0, running}, 32'h0);
        en = '0;

        // ch0 up top=4, free-run; clear alone, then clear coincident with wrap
        vecs.push_back(mk(0, 1, 1, 0, 2'b00, 4, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 2'b00, 4, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 2'b00, 4, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 4, 1, 0, 1, 1));
        // ch2 triangle top=3, then top=0
        vecs.push_back(mk(2, 1, 1, 0, 2'b10, 3, 0, 0, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 1, 0, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 2, 0, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 3, 0, 0, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 2, 1, 1, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 1, 0, 1, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 0, 0, 1, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 1, 1, 1, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 2, 0, 1, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 3, 3, 0, 1, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 0, 0, 1, 1, 1));
        vecs.push_back(mk(2, 0, 1, 0, 2'b10, 0, 0, 1, 1, 1));
        // ch0 top=10 to cnt 6, lower top to 5, gate off, restart mid-run
        vecs.push_back(mk(0, 1, 1, 1, 2'b00, 10, 0, 0, 0, 1));
        for (int c = 1; c <= 6; c++) vecs.push_back(mk(0, 0, 1, 0, 2'b00, 10, 8'(c), 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 5, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00, 5, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00, 5, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00, 5, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 5, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 5, 2, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 2'b00, 5, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00, 5, 1, 0, 1, 1));
        // ch3 down top=7, restart coincident with tick reloads top
        vecs.push_back(mk(3, 1, 1, 0, 2'b01, 7, 7, 0, 0, 1));
        vecs.push_back(mk(3, 0, 1, 0, 2'b01, 7, 6, 0, 0, 1));
        vecs.push_back(mk(3, 0, 1, 0, 2'b01, 7, 5, 0, 0, 1));
        vecs.push_back(mk(3, 1, 1, 0, 2'b01, 7, 7, 0, 0, 1));
        vecs.push_back(mk(3, 0, 1, 0, 2'b01, 7, 6, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            start = '0; en = '0; irq_clr = '0;
            start[v.ch] = v.st;
            en[v.ch] = v.en;
            irq_clr[v.ch] = v.clr;
            oneshot[v.ch] = v.os;
            mode[2*v.ch +: 2] = v.md;
            top[W*v.ch +: W] = v.tp;
            step();
            chk($sformatf("vec%0d cnt", i), {24'h0, cnt[W*v.ch +: W]}, {24'h0, v.cnt});
            chk($sformatf("vec%0d wrap", i), {31'h0, wrap[v.ch]}, {31'h0, v.wr});
            chk($sformatf("vec%0d irq", i), {31'h0, irq[v.ch]}, {31'h0, v.irq});
            chk($sformatf("vec%0d run", i), {31'h0, running[v.ch]}, {31'h0, v.run});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
